qu_fetch_queue: RTL and testbench
=================================

// Module: qu_fetch_queue
// PURPOSE
//  Parametrised instruction fetch queue between the fetch and decode stages of the Qu core.
//  Accepts up to ENQ_WIDTH instructions per cycle from fetch and hands them to decode one
//  per cycle in program order, each with its PC. Decouples fetch/decode stalls.
//  On a redirect (branch, jump or exception) the decode stage drives flush, which empties
//  the queue in a single cycle.
// PARAMETERS
//  INSTR_WIDTH  32  instruction width in bits (QU_INSTR_WIDTH)
//  PC_WIDTH     32  program counter width in bits (QU_PC_WIDTH)
//  DEPTH        8   queue entries; power of two, DEPTH >= ENQ_WIDTH >= 1
//  ENQ_WIDTH    2   instructions fetch may push per cycle (channel count)
//  PC_STEP      4   PC increment between consecutive enqueue slots
// PORTS
//  clk        in   1                       clock, all state updates on posedge
//  rst        in   1                       synchronous, active-high reset
//  flush      in   1                       redirect: discard all queued entries
//  enq_valid  in   ENQ_WIDTH               per-slot valid; bit i = slot i
//  enq_instr  in   ENQ_WIDTH*INSTR_WIDTH   slot i at bits [i*INSTR_WIDTH +: INSTR_WIDTH]
//  enq_pc     in   PC_WIDTH                PC of slot 0
//  enq_ready  out  1                       queue can take a full ENQ_WIDTH group
//  deq_valid  out  1                       head entry is valid
//  deq_instr  out  INSTR_WIDTH             head instruction
//  deq_pc     out  PC_WIDTH                head PC
//  deq_ready  in   1                       decode consumes head this cycle
//  count      out  $clog2(DEPTH+1)         occupied entries
//  full       out  1                       count == DEPTH
//  empty      out  1                       count == 0
// BEHAVIOUR
//  - Reset (rst=1 at posedge): head/tail pointers and count = 0. Outputs after reset:
//    deq_valid=0, deq_instr=0, deq_pc=0, count=0, empty=1, full=0, enq_ready=1.
//  - Storage: DEPTH-entry circular buffer of {pc, instr}; pointers $clog2(DEPTH) bits,
//    wrap naturally at DEPTH-1 -> 0.
//  - enq_ready = (DEPTH - count) >= ENQ_WIDTH, computed from current state only; a same-cycle
//    dequeue does not raise enq_ready.
//  - Enqueue fires when enq_ready && enq_valid[0]. Accepted slots are the contiguous run of
//    set bits from bit 0; bits above the first 0 are ignored. All accepted slots are written
//    in slot order at tail, tail advances by the accepted count (k).
//  - Slot i PC = enq_pc + i*PC_STEP, modulo 2^PC_WIDTH (wraps, no error).
//  - enq_valid while enq_ready=0: nothing written; fetch must hold or re-present the group.
//  - Dequeue fires when deq_valid && deq_ready; head advances by 1.
//  - deq_* are combinational from the head entry; deq_valid = !empty. While empty,
//    deq_instr and deq_pc are forced to 0.
//  - Latency: an entry written at edge N is visible on deq_* after edge N (no bypass from
//    enq inputs to deq outputs when empty).
//  - Simultaneous enqueue and dequeue: count_next = count + k - 1.
//  - flush has priority over everything: at the next edge pointers and count = 0; any
//    enqueue in the same cycle is dropped. A dequeue handshake in the flush cycle is
//    considered consumed by decode; the queue is emptied regardless.
//  - rst has priority over flush; rst asserted mid-stream discards all entries the same
//    way as flush.
//  - full/empty/count always reflect registered state, never the in-flight handshakes.
// TESTING (DEPTH=8, ENQ_WIDTH=2, PC_STEP=4)
//  1. Reset 5 cycles, then enq_valid=2'b11, instr {A,B}, enq_pc=0x100 for 4 cycles, with
//     deq_ready=0 -> count 2,4,6,8; full=1, enq_ready=0 once count >= 7.
//     Then deq_ready=1 -> drains A@0x100, B@0x104, ... in order; empty=1 after 8 pops.
//  2. Steady stream: enq 2/cycle + deq_ready=1 -> count grows by 1/cycle until enq_ready
//     drops at count=7; PCs strictly increase by 4 on deq_pc with no gaps or duplicates.
//  3. enq_valid=2'b10 -> nothing enqueued; enq_valid=2'b01 -> only slot 0 enqueued,
//     count +1.
//  4. Queue holding 5 entries, flush=1 with enq_valid=2'b11 in the same cycle -> next cycle
//     count=0, empty=1, deq_valid=0, deq_instr=0; the enqueued pair is absent.
//  5. Wrap-around: cycle 20+ mixed enq/deq until the tail passes index 7 -> 0 twice; output
//     order is preserved. enq_pc=0xFFFF_FFFC -> slot 1 deq_pc=0x0000_0000.
//  6. Assert rst for 1 cycle with 6 entries queued and deq_ready toggling -> all outputs
//     return to their reset values next cycle; the first post-reset enqueue reads back
//     correctly.

Source files
------------

// File: rtl/qu_fetch_queue.sv
// Qu fetch queue: buffers up to ENQ_WIDTH fetched instructions per cycle
// and hands them to decode one per cycle in program order with their PCs.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   flush          redirect from decode, empties the queue next edge
//   enq_valid      per-slot valid, contiguous run from bit 0 is accepted
//   enq_instr      slot i at [i*INSTR_WIDTH +: INSTR_WIDTH]
//   enq_pc         PC of slot 0, slot i gets enq_pc + i*PC_STEP
//   enq_ready      room for a full ENQ_WIDTH group
//   deq_valid      head entry present
//   deq_instr      head instruction (0 when empty)
//   deq_pc         head PC (0 when empty)
//   deq_ready      decode takes the head this cycle
//   count          occupied entries
//   full, empty    count == DEPTH, count == 0
module qu_fetch_queue #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 32,
  parameter int DEPTH       = 8,
  parameter int ENQ_WIDTH   = 2,
  parameter int PC_STEP     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [ENQ_WIDTH-1:0]           enq_valid,
  input  logic [ENQ_WIDTH*INSTR_WIDTH-1:0] enq_instr,
  input  logic [PC_WIDTH-1:0]            enq_pc,
  output logic                           enq_ready,
  output logic                           deq_valid,
  output logic [INSTR_WIDTH-1:0]         deq_instr,
  output logic [PC_WIDTH-1:0]            deq_pc,
  input  logic                           deq_ready,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ENQ_C   = CW'(ENQ_WIDTH);

  logic [INSTR_WIDTH-1:0] mem_instr [DEPTH];
  logic [PC_WIDTH-1:0]    mem_pc    [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] cnt;
  logic [CW-1:0] k;
  logic [CW-1:0] acc;
  logic          run;
  logic          deq_fire;

  // Length of the contiguous run of valid slots starting at slot 0;
  // anything above the first clear bit is ignored.
  always_comb begin
    k   = '0;
    run = 1'b1;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      if (run && enq_valid[i]) begin
        k = k + CW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // Ready depends on registered occupancy only, so a same-cycle
  // dequeue never opens room for the group.
  assign enq_ready = (DEPTH_C - cnt) >= ENQ_C;
  assign acc       = enq_ready ? k : '0;

  assign count     = cnt;
  assign empty     = (cnt == '0);
  assign full      = (cnt == DEPTH_C);
  assign deq_valid = !empty;
  assign deq_fire  = deq_valid && deq_ready;
  assign deq_instr = empty ? '0 : mem_instr[head];
  assign deq_pc    = empty ? '0 : mem_pc[head];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      tail <= tail + AW'(acc);
      head <= head + AW'(deq_fire);
      cnt  <= cnt + acc - CW'(deq_fire);
    end
  end

  // Payload storage carries no reset; empty entries are masked on output.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int i = 0; i < ENQ_WIDTH; i++) begin
        if (CW'(i) < acc) begin
          mem_instr[tail + AW'(i)] <=
            enq_instr[i*INSTR_WIDTH +: INSTR_WIDTH];
          mem_pc[tail + AW'(i)] <=
            enq_pc + PC_WIDTH'(i * PC_STEP);
        end
      end
    end
  end

endmodule

// File: tb/tb_qu_fetch_queue.sv
// Self-checking bench for qu_fetch_queue (DEPTH=8, ENQ_WIDTH=2).
// Driver pushes expected entries; a negedge monitor pops and compares.
module tb_qu_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  enq_valid;
  logic [63:0] enq_instr;
  logic [31:0] enq_pc;
  logic        enq_ready;
  logic        deq_valid;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc;
  logic        deq_ready;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  qu_fetch_queue #(
    .INSTR_WIDTH(32), .PC_WIDTH(32), .DEPTH(8),
    .ENQ_WIDTH(2), .PC_STEP(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_instr(enq_instr),
    .enq_pc(enq_pc), .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_instr(deq_instr),
    .deq_pc(deq_pc), .deq_ready(deq_ready),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t sb[$];
  int   mcount = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   armed  = 1'b0;
  logic [31:0] next_pc;
  logic [31:0] seq;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: registered-state checks every cycle, and pop on handshake.
  always @(negedge clk) begin
    if (armed) begin
      chk("count", 64'(count), 64'(mcount));
      chk("empty", 64'(empty), 64'(mcount == 0));
      chk("full", 64'(full), 64'(mcount == 8));
      chk("enq_ready", 64'(enq_ready), 64'((8 - mcount) >= 2));
      chk("deq_valid", 64'(deq_valid), 64'(mcount != 0));
      if (!deq_valid) begin
        chk("idle_instr", 64'(deq_instr), 64'd0);
        chk("idle_pc", 64'(deq_pc), 64'd0);
      end else if (deq_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          ent_t e;
          e = sb.pop_front();
          chk("deq_instr", 64'(deq_instr), 64'(e.instr));
          chk("deq_pc", 64'(deq_pc), 64'(e.pc));
        end
      end
    end
  end

  // One clock of stimulus; the model advances at the edge.
  task automatic step(bit r, bit f, logic [1:0] ev,
                      logic [31:0] a, logic [31:0] b,
                      logic [31:0] pc, bit dr);
    bit rdy;
    bit pop;
    int k;
    rst       = r;
    flush     = f;
    enq_valid = ev;
    enq_instr = {b, a};
    enq_pc    = pc;
    deq_ready = dr;
    rdy = (8 - mcount) >= 2;
    pop = (mcount != 0) && dr;
    k   = ev[0] ? (ev[1] ? 2 : 1) : 0;
    @(posedge clk);
    if (r || f) begin
      sb.delete();
      mcount = 0;
    end else begin
      if (rdy && k > 0) begin
        sb.push_back('{pc: pc, instr: a});
        if (k == 2) sb.push_back('{pc: pc + 32'd4, instr: b});
        mcount += k;
      end
      if (pop) mcount -= 1;
    end
    #1;
  endtask

  // Fetch-style stream: advances PC/instr only on acceptance.
  task automatic stream(int n, bit dr_toggle);
    bit dr;
    for (int i = 0; i < n; i++) begin
      bit rdy;
      dr  = dr_toggle ? bit'(i % 3 != 0) : 1'b1;
      rdy = (8 - mcount) >= 2;
      step(0, 0, 2'b11, seq, seq + 32'd1, next_pc, dr);
      if (rdy) begin
        next_pc = next_pc + 32'd8;
        seq     = seq + 32'd2;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) step(0, 0, 2'b00, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; enq_valid = '0;
    enq_instr = '0; enq_pc = '0; deq_ready = 1'b0;
    next_pc = 32'h0000_2000;
    seq     = 32'hC000_0000;

    // Reset for 5 cycles; monitor starts after the first edge.
    step(1, 0, 2'b00, 0, 0, 0, 0);
    armed = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 0, 2'b00, 0, 0, 0, 0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(enq_ready), 64'd1);

    // Fill with A/B pairs, deq stalled: 2,4,6,8 then full.
    for (int i = 0; i < 4; i++)
      step(0, 0, 2'b11, 32'hAAAA_0000 + i, 32'hBBBB_0000 + i,
           32'h100 + 32'(i * 8), 0);
    chk("fill_count", 64'(count), 64'd8);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_ready", 64'(enq_ready), 64'd0);
    chk("fill_head_pc", 64'(deq_pc), 64'h100);
    // A group presented while not ready is dropped.
    step(0, 0, 2'b11, 32'hDEAD, 32'hBEEF, 32'h900, 0);
    drain();
    chk("drain_empty", 64'(empty), 64'd1);

    // Steady stream: 2 in, 1 out per cycle.
    stream(16, 0);
    drain();

    // Partial valids: 10 ignored, 01 takes slot 0 only.
    step(0, 0, 2'b10, 32'h1111, 32'h2222, 32'h400, 0);
    chk("ev10_count", 64'(count), 64'd0);
    step(0, 0, 2'b01, 32'h3333, 32'h4444, 32'h500, 0);
    chk("ev01_count", 64'(count), 64'd1);
    chk("ev01_instr", 64'(deq_instr), 64'h3333);
    chk("ev01_pc", 64'(deq_pc), 64'h500);

    // Build 5 entries, then flush alongside an enqueue.
    step(0, 0, 2'b11, 32'h5001, 32'h5002, 32'h600, 0);
    step(0, 0, 2'b11, 32'h5003, 32'h5004, 32'h608, 0);
    chk("pre_flush_count", 64'(count), 64'd5);
    step(0, 1, 2'b11, 32'h6666, 32'h7777, 32'h700, 1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(deq_valid), 64'd0);
    chk("flush_instr", 64'(deq_instr), 64'd0);
    step(0, 0, 2'b00, 0, 0, 0, 1);

    // Wrap-around with irregular dequeue.
    stream(40, 1);
    drain();

    // PC wraps at the top of the address space.
    step(0, 0, 2'b11, 32'hE000_0001, 32'hE000_0002, 32'hFFFF_FFFC, 0);
    chk("wrap_pc0", 64'(deq_pc), 64'hFFFF_FFFC);
    step(0, 0, 2'b00, 0, 0, 0, 1);
    chk("wrap_pc1", 64'(deq_pc), 64'h0);
    chk("wrap_instr1", 64'(deq_instr), 64'hE000_0002);
    drain();

    // Mid-stream reset with 6 entries and toggling deq_ready.
    for (int i = 0; i < 3; i++)
      step(0, 0, 2'b11, 32'h7000 + 32'(2*i), 32'h7001 + 32'(2*i),
           32'h800 + 32'(i * 8), 0);
    chk("pre_rst_count", 64'(count), 64'd6);
    step(0, 0, 2'b00, 0, 0, 0, 1);
    step(1, 0, 2'b11, 32'h9999, 32'h9998, 32'hA00, 0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_pc", 64'(deq_pc), 64'd0);
    step(0, 0, 2'b01, 32'h8888, 0, 32'hB00, 0);
    chk("post_rst_instr", 64'(deq_instr), 64'h8888);
    chk("post_rst_pc", 64'(deq_pc), 64'hB00);
    drain();
    chk("sb_leftover", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
